// File: rtl/edid_block_checker.sv
// edid_block_checker: buffers one EDID block, checks header/checksum, extracts mfg ID (optional letter decode: EDID_MFG_DECODE_EN)
module edid_block_checker #(
    parameter int BLOCK_BYTES = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk_4MHz,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              done,
    output logic              header_ok,
    output logic              checksum_ok,
    output logic              err,
    output logic [15:0]       mfg_id,
`ifdef EDID_MFG_DECODE_EN
    output logic [14:0]       mfg_chars,
`endif
    output logic [ADDR_W:0]   byte_count,
    output logic [2:0]        state_dbg
);
    typedef enum logic [2:0] {IDLE = 3'd0, HDR = 3'd1, BODY = 3'd2, DONE = 3'd3, ERR = 3'd4} state_t;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(BLOCK_BYTES - 1);
    localparam logic [ADDR_W:0] IDX8 = (ADDR_W+1)'(8);
    localparam logic [ADDR_W:0] IDX9 = (ADDR_W+1)'(9);
    state_t state, state_nx;
    logic [7:0] mem [BLOCK_BYTES];
    logic [7:0] sum;
    logic xfer, at_last, hdr_bad;
    assign in_ready  = state == HDR || state == BODY;
    assign xfer      = in_valid && in_ready && !frame_start;
    assign at_last   = byte_count == LAST;
    assign hdr_bad   = in_data != ((byte_count[2:0] == 3'd0 || byte_count[2:0] == 3'd7) ? 8'h00 : 8'hFF);
    assign done      = state == DONE || state == ERR;
    assign err       = state == ERR;
    assign state_dbg = state;
`ifdef EDID_MFG_DECODE_EN
    logic [14:0] chars;
    assign chars = {mfg_id[14:8], in_data};
    function automatic logic bad_letter(input logic [4:0] l);
        return l == 5'd0 || l > 5'd26;
    endfunction
`endif
    // state register
    always_ff @(posedge clk_4MHz) begin
        state <= rst ? IDLE : state_nx;
    end
    // next state: restart wins, then termination (in_last or last index), then header -> body
    always_comb begin
        state_nx = state;
        if (frame_start) state_nx = HDR;
        else if (xfer && (in_last || at_last)) state_nx = (in_last && at_last) ? DONE : ERR;
        else if (xfer && state == HDR && byte_count[2:0] == 3'd7) state_nx = BODY;
    end
    // per-byte bookkeeping: count, running sum, header/checksum flags, manufacturer ID
    always_ff @(posedge clk_4MHz) begin
        if (rst) begin
            byte_count  <= '0;
            sum         <= '0;
            header_ok   <= 1'b0;
            checksum_ok <= 1'b0;
            mfg_id      <= '0;
        end else if (frame_start) begin
            byte_count  <= '0;
            sum         <= '0;
            header_ok   <= 1'b1;
            checksum_ok <= 1'b0;
            mfg_id      <= '0;
        end else if (xfer) begin
            byte_count  <= byte_count + 1'b1;
            sum         <= sum + in_data;
            checksum_ok <= in_last && at_last && (sum + in_data) == 8'd0;
            if (state == HDR && hdr_bad) header_ok <= 1'b0;
            if (byte_count == IDX8) mfg_id[15:8] <= in_data;
            if (byte_count == IDX9) mfg_id[7:0] <= in_data;
`ifdef EDID_MFG_DECODE_EN
            if (byte_count == IDX9 && (bad_letter(chars[14:10]) || bad_letter(chars[9:5]) || bad_letter(chars[4:0])))
                header_ok <= 1'b0;
`endif
        end
    end
`ifdef EDID_MFG_DECODE_EN
    // decoded letters latch together with the second manufacturer byte
    always_ff @(posedge clk_4MHz) begin
        if (rst || frame_start) mfg_chars <= '0;
        else if (xfer && byte_count == IDX9) mfg_chars <= chars;
    end
`endif
    // block buffer write; contents survive reset
    always_ff @(posedge clk_4MHz) begin
        if (xfer) mem[byte_count[ADDR_W-1:0]] <= in_data;
    end
    // registered browse port, read-before-write on address collision
    always_ff @(posedge clk_4MHz) begin
        rd_data <= rst ? 8'h00 : mem[rd_addr];
    end
endmodule
